// File: rtl/riscv_dmem_arbiter.sv
// Two-port data-memory arbiter: core has default priority, DMA may hold locked bursts.
// Optional starvation limiter for the DMA port is enabled by RISCV_DMEM_ARB_STARVE_EN.
//
// state    | meaning
// ST_IDLE  | per-cycle arbitration, core first (unless starvation override)
// ST_DLOCK | DMA owns the memory for up to LOCK_MAX consecutive locked beats
module riscv_dmem_arbiter #(
    parameter int XLEN       = 32,
    parameter int LOCK_MAX   = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_c_req,
    input  logic            i_c_wr,
    input  logic [XLEN-1:0] i_c_addr,
    input  logic [XLEN-1:0] i_c_wdata,
    input  logic [3:0]      i_c_byte_sel,
    output logic            o_c_gnt,
    output logic            o_c_rvalid,
    output logic [XLEN-1:0] o_c_rdata,
    input  logic            i_d_req,
    input  logic            i_d_wr,
    input  logic [XLEN-1:0] i_d_addr,
    input  logic [XLEN-1:0] i_d_wdata,
    input  logic [3:0]      i_d_byte_sel,
    input  logic            i_d_lock,
    output logic            o_d_gnt,
    output logic            o_d_rvalid,
    output logic [XLEN-1:0] o_d_rdata,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_data,
    output logic [3:0]      o_dmem_byte_sel,
    output logic            o_dmem_wr_en,
    input  logic [XLEN-1:0] i_dmem_data
);

    localparam int LCW = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_MAX);

    if (LOCK_MAX < 1 || STARVE_MAX < 1) begin : g_param_check
        $error("riscv_dmem_arbiter: LOCK_MAX and STARVE_MAX must be >= 1");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DLOCK = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [LCW-1:0] lock_cnt, lock_cnt_nxt;
    logic           c_gnt, d_gnt;
    logic           starve_force;
    logic           lock_done;

`ifdef RISCV_DMEM_ARB_STARVE_EN
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0] starve_cnt;

    // Counts cycles DMA asked but lost; saturates so the override stays armed until used.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            starve_cnt <= '0;
        end else if (!i_d_req || d_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starve_force = (starve_cnt == STARVE_LIM);
`else
    assign starve_force = 1'b0;
`endif

    assign lock_done = (state == ST_DLOCK) && (lock_cnt == LOCK_LIM);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    always_comb begin
        c_gnt        = 1'b0;
        d_gnt        = 1'b0;
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        if (state == ST_DLOCK && i_d_req && i_d_lock && lock_cnt < LOCK_LIM) begin
            d_gnt        = 1'b1;
            lock_cnt_nxt = lock_cnt + 1'b1;
        end else begin
            // Idle rules; a burst that just hit LOCK_MAX yields to the core unconditionally.
            if (starve_force && i_d_req && !(lock_done && i_c_req)) begin
                d_gnt = 1'b1;
            end else if (i_c_req) begin
                c_gnt = 1'b1;
            end else if (i_d_req) begin
                d_gnt = 1'b1;
            end
            state_nxt    = ST_IDLE;
            lock_cnt_nxt = '0;
            if (d_gnt && i_d_lock) begin
                state_nxt    = ST_DLOCK;
                lock_cnt_nxt = LCW'(1);
            end
        end
    end

    assign o_c_gnt = c_gnt;
    assign o_d_gnt = d_gnt;

    always_comb begin
        o_dmem_addr     = '0;
        o_dmem_data     = '0;
        o_dmem_byte_sel = '0;
        o_dmem_wr_en    = 1'b0;
        if (c_gnt) begin
            o_dmem_addr     = i_c_addr;
            o_dmem_data     = i_c_wdata;
            o_dmem_byte_sel = i_c_byte_sel;
            o_dmem_wr_en    = i_c_wr & i_rstn;
        end else if (d_gnt) begin
            o_dmem_addr     = i_d_addr;
            o_dmem_data     = i_d_wdata;
            o_dmem_byte_sel = i_d_byte_sel;
            o_dmem_wr_en    = i_d_wr & i_rstn;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_c_rvalid <= 1'b0;
            o_d_rvalid <= 1'b0;
            o_c_rdata  <= '0;
            o_d_rdata  <= '0;
        end else begin
            o_c_rvalid <= c_gnt & ~i_c_wr;
            o_d_rvalid <= d_gnt & ~i_d_wr;
            if (c_gnt && !i_c_wr) o_c_rdata <= i_dmem_data;
            if (d_gnt && !i_d_wr) o_d_rdata <= i_dmem_data;
        end
    end

endmodule
